parking_entry_ctrl: RTL and testbench
=====================================

Name: parking_entry_ctrl

Overview:
Downstream of the lot-selection stage. Consumes the selected lot number (1 or 2) and the debounced button and keypad vectors, and runs the car entry and exit transactions.
- Entry: allocates the lowest free slot in the selected lot and timestamps it.
- Exit: frees a keypad-chosen slot and computes the parking fee from elapsed ticks.
- Drives status, slot, fee and free-count values to the display/view logic.

Parameters:
CAPACITY, 8, slots per lot (1..8); slot index is 3 bits.
TICK_DIV, 100_000_000, clk cycles per billing tick (1 s at 100 MHz).
RATE, 2, fee units per elapsed tick (4-bit value).
SHOW_CYCLES, 300_000_000, cycles a result is held before returning to IDLE.
FEE_MAX, 9999, fee saturation value.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
bt_out  in  5  debounced button levels; [3] = confirm entry, [2] = confirm exit
view  in  3  UI page; entry is accepted only at 0, exit only at 1
lot_sel  in  3  lot chosen upstream; valid values 1, 2
key_out  in  16  keypad levels; [7:0] selects the slot to release
status  out  3  0 idle, 1 entered, 2 lot full, 3 exited, 4 error
slot_idx  out  3  slot allocated or released
lot_out  out  2  lot of the last transaction
fee  out  14  fee of the last exit, saturated at FEE_MAX
free1  out  4  free slots in lot 1
free2  out  4  free slots in lot 2
busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Reset: FSM = IDLE; occupancy bitmaps = 0; timestamps = 0; tick prescaler and now counter = 0.
- Reset outputs: status = 0, slot_idx = 0, lot_out = 0, fee = 0, free1 = free2 = CAPACITY, busy = 0. rst mid-transaction aborts the transaction with no bitmap change.
- Time base: prescaler counts 0..TICK_DIV-1. On wrap, 16-bit now increments modulo 2^16 and runs in every state.
- Edge detect:
  - ent_ev = rising edge of bt_out[3], registered previous-sample compare.
  - ext_ev = rising edge of (|key_out[7:0]) while bt_out[2] is high.
  - Events are sampled only in IDLE; events in any other state are dropped, with no queueing.
- IDLE:
  - ent_ev with view == 0 -> ALLOC.
  - ext_ev with view == 1 -> RELEASE.
  - Both on the same cycle cannot qualify, since view differs. If view qualifies neither, ignore.
  - Latch lot_sel and key_out[7:0] on the transition.
- ALLOC, one cycle:
  - Lot not in {1, 2} -> status = 4, go to SHOW.
  - Else priority-encode the lowest 0 bit among slots 0..CAPACITY-1 of that lot.
  - Free slot found: set its bit, stamp[lot][slot] = now, slot_idx = slot, status = 1.
  - None free: status = 2, slot_idx unchanged.
  - lot_out = lot; go to SHOW.
- RELEASE, one cycle:
  - Slot = index of lowest set bit of the latched key byte.
  - Error (status = 4, no state change) if slot >= CAPACITY, lot is invalid, or the slot is not occupied.
  - Otherwise clear the bit, set elapsed = now - stamp (16-bit modulo, so wrap is correct) and go to FEEC.
- FEEC, one cycle: product = elapsed * RATE (20 bits); fee = min(product, FEE_MAX); status = 3; slot_idx = slot; lot_out = lot; go to SHOW.
- SHOW:
  - Outputs held.
  - Counter runs 0..SHOW_CYCLES-1, then IDLE with status = 0. slot_idx, lot_out and fee keep their last values.
- Latency: an event edge registered at cycle N gives results visible at N+2 (entry) or N+3 (exit).
- Free counts: free1/free2 are registered popcount complements of their bitmaps, updated the cycle after any bitmap change.
- busy = (state != IDLE).
- Allocation never exceeds CAPACITY. free never underflows or exceeds CAPACITY.

Decomposition:
- Package parking_pkg holds:
  - FSM state enum: IDLE, ALLOC, RELEASE, FEEC, SHOW.
  - Status codes ST_IDLE..ST_ERR.
  - LOT1 = 1, LOT2 = 2.
  - View codes VIEW_ENTRY = 0, VIEW_EXIT = 1.
- One sub-module, slot_finder: combinational lowest-zero priority encoder with a found flag. It is instantiated for the allocation search and, fed the inverted key byte, for release selection.

Test Plan:
(Sim parameters: CAPACITY = 4, TICK_DIV = 4, SHOW_CYCLES = 8, RATE = 2.)
1. After rst, view = 0, lot_sel = 1, pulse bt_out[3] -> status = 1, slot_idx = 0, lot_out = 1, free1 = 3 two cycles after the edge; status = 0 after 8 SHOW cycles.
2. Fill lot 2 with four entries, then a fifth -> status = 2, free2 = 0, bitmap unchanged; lot 1 is unaffected (free1 = 4).
3. Entry to lot 1 slot 0, wait 40 cycles (10 ticks), view = 1, bt_out[2] held, key_out = 16'h0001 -> status = 3, fee = 20, free1 back to 4.
4. Exit of an unoccupied slot (key_out = 16'h0004) or lot_sel = 3 -> status = 4, no bitmap or free change.
5. Force now near 16'hFFFE at entry, exit after the wrap to 16'h0003 -> elapsed = 5, fee = 10. Separately, an elapsed value with product > 9999 -> fee = 9999.
6. Assert rst during SHOW and again in the ALLOC cycle -> all outputs return to reset values next cycle. A second bt_out[3] edge during SHOW -> ignored, free count unchanged.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and codes for the parking entry/exit controller.
package parking_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_RELEASE,
        S_FEEC,
        S_SHOW
    } state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTERED = 3'd1;
    localparam logic [2:0] ST_FULL    = 3'd2;
    localparam logic [2:0] ST_EXITED  = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    localparam logic [2:0] LOT1 = 3'd1;
    localparam logic [2:0] LOT2 = 3'd2;

    localparam logic [2:0] VIEW_ENTRY = 3'd0;
    localparam logic [2:0] VIEW_EXIT  = 3'd1;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/parking_entry_ctrl_slot_finder.sv
// Lowest-zero priority encoder over N slot bits.
module slot_finder #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_bits,
    output logic [2:0]   o_idx,
    output logic         o_found
);

    // Scan high to low so the lowest zero wins.
    always_comb begin
        o_idx   = 3'd0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_bits[i]) begin
                o_idx   = 3'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_entry_ctrl.sv
// Car entry/exit transactions: slot allocation, timestamping and
// exit fee computation for two lots.
module parking_entry_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int TICK_DIV    = 100_000_000,
    parameter int RATE        = 2,
    parameter int SHOW_CYCLES = 300_000_000,
    parameter int FEE_MAX     = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  bt_out,
    input  logic [2:0]  view,
    input  logic [2:0]  lot_sel,
    input  logic [15:0] key_out,
    output logic [2:0]  status,
    output logic [2:0]  slot_idx,
    output logic [1:0]  lot_out,
    output logic [13:0] fee,
    output logic [3:0]  free1,
    output logic [3:0]  free2,
    output logic        busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t              r_state, w_state_nx;
    logic [PW-1:0]       r_presc;
    logic [15:0]         r_now;
    logic                r_bt3_q, r_key_any_q;
    logic [CW-1:0]       r_cnt, w_cnt_nx;
    logic [CAPACITY-1:0] r_map1, r_map2, w_map1_nx, w_map2_nx;
    logic [15:0]         r_stamp [2][8];
    logic [15:0]         r_elapsed, w_elapsed_nx;
    logic [2:0]          r_lat_lot, w_lat_lot_nx;
    logic [7:0]          r_lat_key, w_lat_key_nx;
    logic [2:0]          r_status, w_status_nx;
    logic [2:0]          r_slot, w_slot_nx;
    logic [1:0]          r_lot, w_lot_nx;
    logic [13:0]         r_fee, w_fee_nx;
    logic [3:0]          r_free1, r_free2;
    logic                w_stamp_we;

    logic                w_key_any, w_ent_ev, w_ext_ev;
    logic                w_lot_ok, w_lsel;
    logic [CAPACITY-1:0] w_cur_map, w_alloc_oh, w_rel_oh;
    logic [2:0]          w_alloc_idx, w_rel_idx;
    logic                w_alloc_found, w_rel_found, w_rel_ok;
    logic [7:0]          w_key_n;
    logic [19:0]         w_prod;
    logic                w_unused;

    assign w_unused  = ^{bt_out[4], bt_out[1:0], key_out[15:8]};
    assign w_key_any = |key_out[7:0];
    assign w_ent_ev  = bt_out[3] & ~r_bt3_q;
    assign w_ext_ev  = w_key_any & ~r_key_any_q & bt_out[2];

    assign w_lsel    = (r_lat_lot == LOT2);
    assign w_lot_ok  = (r_lat_lot == LOT1) || (r_lat_lot == LOT2);
    assign w_cur_map = w_lsel ? r_map2 : r_map1;
    assign w_key_n   = ~r_lat_key;

    slot_finder #(.N(CAPACITY)) u_alloc (
        .i_bits  (w_cur_map),
        .o_idx   (w_alloc_idx),
        .o_found (w_alloc_found)
    );

    slot_finder #(.N(8)) u_rel (
        .i_bits  (w_key_n),
        .o_idx   (w_rel_idx),
        .o_found (w_rel_found)
    );

    // Shifting past CAPACITY yields zero, so out-of-range slots read as free.
    assign w_alloc_oh = CAPACITY'(1) << w_alloc_idx;
    assign w_rel_oh   = CAPACITY'(1) << w_rel_idx;
    assign w_rel_ok   = w_rel_found && w_lot_ok && (|(w_cur_map & w_rel_oh));
    assign w_prod     = 20'(r_elapsed) * 20'(RATE);

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_map1_nx    = r_map1;
        w_map2_nx    = r_map2;
        w_elapsed_nx = r_elapsed;
        w_lat_lot_nx = r_lat_lot;
        w_lat_key_nx = r_lat_key;
        w_status_nx  = r_status;
        w_slot_nx    = r_slot;
        w_lot_nx     = r_lot;
        w_fee_nx     = r_fee;
        w_stamp_we   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_ent_ev && view == VIEW_ENTRY) begin
                    w_state_nx   = S_ALLOC;
                    w_lat_lot_nx = lot_sel;
                    w_lat_key_nx = key_out[7:0];
                end else if (w_ext_ev && view == VIEW_EXIT) begin
                    w_state_nx   = S_RELEASE;
                    w_lat_lot_nx = lot_sel;
                    w_lat_key_nx = key_out[7:0];
                end
            end
            S_ALLOC: begin
                w_state_nx = S_SHOW;
                w_cnt_nx   = '0;
                if (!w_lot_ok) begin
                    w_status_nx = ST_ERR;
                end else if (w_alloc_found) begin
                    if (w_lsel) w_map2_nx = r_map2 | w_alloc_oh;
                    else        w_map1_nx = r_map1 | w_alloc_oh;
                    w_stamp_we  = 1'b1;
                    w_slot_nx   = w_alloc_idx;
                    w_status_nx = ST_ENTERED;
                    w_lot_nx    = r_lat_lot[1:0];
                end else begin
                    w_status_nx = ST_FULL;
                    w_lot_nx    = r_lat_lot[1:0];
                end
            end
            S_RELEASE: begin
                if (w_rel_ok) begin
                    if (w_lsel) w_map2_nx = r_map2 & ~w_rel_oh;
                    else        w_map1_nx = r_map1 & ~w_rel_oh;
                    w_elapsed_nx = r_now - r_stamp[w_lsel][w_rel_idx];
                    w_state_nx   = S_FEEC;
                end else begin
                    w_status_nx = ST_ERR;
                    w_state_nx  = S_SHOW;
                    w_cnt_nx    = '0;
                end
            end
            S_FEEC: begin
                w_fee_nx    = (w_prod > 20'(FEE_MAX)) ? 14'(FEE_MAX)
                                                      : w_prod[13:0];
                w_status_nx = ST_EXITED;
                w_slot_nx   = w_rel_idx;
                w_lot_nx    = r_lat_lot[1:0];
                w_state_nx  = S_SHOW;
                w_cnt_nx    = '0;
            end
            S_SHOW: begin
                if (r_cnt == CW'(SHOW_CYCLES - 1)) begin
                    w_state_nx  = S_IDLE;
                    w_status_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_now       <= '0;
            r_bt3_q     <= 1'b0;
            r_key_any_q <= 1'b0;
            r_cnt       <= '0;
            r_map1      <= '0;
            r_map2      <= '0;
            r_elapsed   <= '0;
            r_lat_lot   <= '0;
            r_lat_key   <= '0;
            r_status    <= ST_IDLE;
            r_slot      <= '0;
            r_lot       <= '0;
            r_fee       <= '0;
            r_free1     <= 4'(CAPACITY);
            r_free2     <= 4'(CAPACITY);
            for (int l = 0; l < 2; l++)
                for (int s = 0; s < 8; s++)
                    r_stamp[l][s] <= '0;
        end else begin
            if (r_presc == PW'(TICK_DIV - 1)) begin
                r_presc <= '0;
                r_now   <= r_now + 16'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_bt3_q     <= bt_out[3];
            r_key_any_q <= w_key_any;
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_map1      <= w_map1_nx;
            r_map2      <= w_map2_nx;
            r_elapsed   <= w_elapsed_nx;
            r_lat_lot   <= w_lat_lot_nx;
            r_lat_key   <= w_lat_key_nx;
            r_status    <= w_status_nx;
            r_slot      <= w_slot_nx;
            r_lot       <= w_lot_nx;
            r_fee       <= w_fee_nx;
            r_free1     <= 4'(CAPACITY) - popcnt8(8'(r_map1));
            r_free2     <= 4'(CAPACITY) - popcnt8(8'(r_map2));
            if (w_stamp_we) r_stamp[w_lsel][w_alloc_idx] <= r_now;
        end
    end

    assign status   = r_status;
    assign slot_idx = r_slot;
    assign lot_out  = r_lot;
    assign fee      = r_fee;
    assign free1    = r_free1;
    assign free2    = r_free2;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_parking_entry_ctrl.sv
// Directed bench for parking_entry_ctrl with CAPACITY=4, TICK_DIV=4,
// SHOW_CYCLES=8, RATE=2.
module tb_parking_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  bt_out;
    logic [2:0]  view;
    logic [2:0]  lot_sel;
    logic [15:0] key_out;
    logic [2:0]  status;
    logic [2:0]  slot_idx;
    logic [1:0]  lot_out;
    logic [13:0] fee;
    logic [3:0]  free1;
    logic [3:0]  free2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    parking_entry_ctrl #(
        .CAPACITY    (4),
        .TICK_DIV    (4),
        .RATE        (2),
        .SHOW_CYCLES (8),
        .FEE_MAX     (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bt_out   (bt_out),
        .view     (view),
        .lot_sel  (lot_sel),
        .key_out  (key_out),
        .status   (status),
        .slot_idx (slot_idx),
        .lot_out  (lot_out),
        .fee      (fee),
        .free1    (free1),
        .free2    (free2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bt_out  = '0;
        key_out = '0;
        view    = 3'd0;
        lot_sel = 3'd1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick(1);
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Leaves the bench at the negedge after edge+2 posedges.
    task automatic entry(input logic [2:0] lot);
        lot_sel   = lot;
        view      = 3'd0;
        bt_out[3] = 1'b1;
        tick(3);
        bt_out[3] = 1'b0;
    endtask

    task automatic do_exit(input logic [2:0] lot, input logic [15:0] key);
        lot_sel   = lot;
        view      = 3'd1;
        bt_out[2] = 1'b1;
        key_out   = key;
        tick(3);
        key_out   = '0;
        bt_out[2] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bt_out  = '0;
        view    = '0;
        lot_sel = 3'd1;
        key_out = '0;

        do_reset();
        chk("rst_status", status, 0);
        chk("rst_slot", slot_idx, 0);
        chk("rst_lot", lot_out, 0);
        chk("rst_fee", fee, 0);
        chk("rst_free1", free1, 4);
        chk("rst_free2", free2, 4);
        chk("rst_busy", busy, 0);

        // single entry and SHOW hold length
        entry(3'd1);
        chk("t1_status", status, 1);
        chk("t1_slot", slot_idx, 0);
        chk("t1_lot", lot_out, 1);
        chk("t1_free1", free1, 3);
        chk("t1_busy", busy, 1);
        tick(6);
        chk("t1_show_hold", status, 1);
        chk("t1_show_busy", busy, 1);
        tick(1);
        chk("t1_idle_status", status, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_keep_slot", slot_idx, 0);
        chk("t1_keep_lot", lot_out, 1);

        // fill lot 2 then overflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            entry(3'd2);
            chk("t2_fill_status", status, 1);
            chk("t2_fill_slot", slot_idx, 32'(i));
            chk("t2_fill_free2", free2, 32'(3 - i));
            wait_idle();
        end
        entry(3'd2);
        chk("t2_full_status", status, 2);
        chk("t2_full_slot", slot_idx, 3);
        chk("t2_full_lot", lot_out, 2);
        chk("t2_full_free2", free2, 0);
        chk("t2_full_free1", free1, 4);
        wait_idle();
        chk("t2_full_free2_after", free2, 0);

        // exit 40 cycles after entry -> 10 ticks -> fee 20
        do_reset();
        entry(3'd1);
        chk("t3_entry_slot", slot_idx, 0);
        tick(37);
        do_exit(3'd1, 16'h0001);
        chk("t3_status", status, 3);
        chk("t3_fee", fee, 20);
        chk("t3_slot", slot_idx, 0);
        chk("t3_lot", lot_out, 1);
        chk("t3_free1", free1, 4);
        wait_idle();
        chk("t3_fee_kept", fee, 20);

        // error paths
        entry(3'd1);
        chk("t4_entry_free1", free1, 3);
        wait_idle();
        do_exit(3'd1, 16'h0004);
        chk("t4_unocc_status", status, 4);
        chk("t4_unocc_free1", free1, 3);
        chk("t4_unocc_fee", fee, 20);
        wait_idle();
        do_exit(3'd1, 16'h0010);
        chk("t4_range_status", status, 4);
        chk("t4_range_free1", free1, 3);
        wait_idle();
        do_exit(3'd3, 16'h0001);
        chk("t4_badlot_x_status", status, 4);
        chk("t4_badlot_x_free1", free1, 3);
        wait_idle();
        entry(3'd3);
        chk("t4_badlot_e_status", status, 4);
        chk("t4_badlot_e_free1", free1, 3);
        chk("t4_badlot_e_free2", free2, 4);
        wait_idle();
        do_exit(3'd1, 16'h0003);
        chk("t4_multikey_status", status, 3);
        chk("t4_multikey_slot", slot_idx, 0);
        chk("t4_multikey_free1", free1, 4);
        wait_idle();

        // timestamp wrap: stamp near FFFE, exit 20 cycles later
        do_reset();
        force dut.r_now = 16'hFFFE;
        tick(1);
        release dut.r_now;
        entry(3'd1);
        chk("t5_wrap_entry", status, 1);
        tick(17);
        do_exit(3'd1, 16'h0001);
        chk("t5_wrap_status", status, 3);
        chk("t5_wrap_fee", fee, 10);
        wait_idle();

        // saturation
        entry(3'd1);
        wait_idle();
        force dut.r_now = 16'd9000;
        tick(1);
        release dut.r_now;
        do_exit(3'd1, 16'h0001);
        chk("t5_sat_status", status, 3);
        chk("t5_sat_fee", fee, 9999);
        chk("t5_sat_free1", free1, 4);
        wait_idle();

        // reset during SHOW
        entry(3'd1);
        chk("t6_pre_free1", free1, 3);
        rst = 1'b1;
        tick(1);
        chk("t6_show_status", status, 0);
        chk("t6_show_slot", slot_idx, 0);
        chk("t6_show_lot", lot_out, 0);
        chk("t6_show_fee", fee, 0);
        chk("t6_show_free1", free1, 4);
        chk("t6_show_busy", busy, 0);
        rst = 1'b0;
        tick(1);

        // reset in the ALLOC cycle
        lot_sel   = 3'd2;
        view      = 3'd0;
        bt_out[3] = 1'b1;
        tick(1);
        chk("t6_alloc_busy_pre", busy, 1);
        rst = 1'b1;
        tick(1);
        chk("t6_alloc_busy", busy, 0);
        chk("t6_alloc_status", status, 0);
        chk("t6_alloc_lot", lot_out, 0);
        rst       = 1'b0;
        bt_out[3] = 1'b0;
        tick(2);
        chk("t6_alloc_free2", free2, 4);

        // second entry edge during SHOW is dropped
        entry(3'd1);
        chk("t6_dup_first", free1, 3);
        tick(1);
        bt_out[3] = 1'b1;
        tick(2);
        chk("t6_dup_busy", busy, 1);
        bt_out[3] = 1'b0;
        wait_idle();
        tick(3);
        chk("t6_dup_free1", free1, 3);
        chk("t6_dup_status", status, 0);
        chk("t6_dup_slot", slot_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
